burst_reg_bank: RTL and testbench
=================================

// Module: burst_reg_bank
// PURPOSE
//  Parametrised register bank between the APB register controller (RC) and the data burst
//  controller (DB). Holds a DEPTH-entry data buffer and the LENGTH/MAX_BURST/CTRL/STATUS registers.
//  A transfer FSM sequences start -> busy -> done. Adds sticky status, error flags and an interrupt.
// PARAMETERS
//  DATA_W   8    width of buffer entries and registers
//  DEPTH    256  buffer entries; power of two, >= 4
//  ADDR_W   $clog2(DEPTH)+1  RC address width (buffer + register window)
// PORTS
//  clk                  in   1       single clock, rising edge
//  rst                  in   1       asynchronous, active-high reset
//  rc_rb_req            in   1       RC access request, single-cycle
//  rc_rb_rw             in   1       1 = write, 0 = read
//  rc_rb_addr           in   ADDR_W  RC address
//  rc_rb_wdata          in   DATA_W  RC write data
//  rb_rc_ack            out  1       one-cycle ack, 1 clk after req
//  rb_rc_rdata          out  DATA_W  read data, valid with ack
//  db_rb_req            in   1       DB buffer access request
//  db_rb_we             in   1       1 = DB writes the buffer (burst read), 0 = DB reads it
//  db_rb_addr           in   ADDR_W-1  buffer index
//  db_rb_wdata          in   DATA_W  DB write data
//  rb_db_ack            out  1       one-cycle ack, 1 clk after req
//  rb_db_rdata          out  DATA_W  buffer data, valid with ack
//  db_rb_done           in   1       DB transfer complete, one-cycle pulse
//  rb_db_start          out  1       one-cycle start pulse to DB
//  rb_db_rw             out  1       CTRL.dir, held while busy
//  rb_db_length         out  DATA_W  LENGTH register
//  rb_db_max_burst_size out  DATA_W  MAX_BURST register
//  irq                  out  1       STATUS.done & CTRL.irq_en
//  idle                 out  1       FSM in IDLE and no request pending
// BEHAVIOUR
//  Map: 0..DEPTH-1 buffer; DEPTH+0 LENGTH; +1 MAX_BURST; +2 CTRL; +3 STATUS; others read 0, writes dropped.
//  CTRL: bit0 start (write-1 triggers, reads 0); bit1 dir (1 = buffer->burst); bit2 irq_en.
//  STATUS (read-only except W1C): bit0 busy; bit1 done (sticky, W1C); bit2 err (sticky, W1C).
//  Reset: all outputs 0; registers 0; buffer contents undefined (not reset).
//  FSM IDLE: RC write CTRL.start=1 -> if LENGTH==0, set done and stay in IDLE (no start pulse);
//    otherwise latch dir and go to START.
//  START: rb_db_start=1 for exactly one cycle; busy=1 -> BUSY.
//  BUSY: wait for db_rb_done -> DONE. db_rb_done outside BUSY is ignored.
//  DONE: set STATUS.done, clear busy -> IDLE. irq rises the cycle after DONE.
//  While busy (START/BUSY/DONE): RC writes to buffer, LENGTH, MAX_BURST, or CTRL.dir/start are
//    dropped and set err. RC reads still ack; buffer reads while busy return 0 and set err.
//  Buffer is single-port: DB owns it while busy; RC owns it in IDLE. A DB req in IDLE acks with
//    rdata 0 and has no write effect.
//  Same-cycle RC W1C of done and done set by the FSM: the set wins.
//  A new RC req while ack is high is served back-to-back (ack again the next cycle).
//  Address wrap: DB index is taken modulo DEPTH; no out-of-range DB access exists.
//  Reset mid-transfer: FSM returns to IDLE asynchronously; no further rb_db_start pulse.
// STRUCTURE
//  Shared package burst_pkg: register offsets (LENGTH_OFF..STATUS_OFF), CTRL/STATUS bit indices,
//    FSM state enum {IDLE, START, BUSY, DONE}.
//  One sub-module: brb_buffer (DEPTH x DATA_W single-port RAM, 1-cycle read, muxed by owner).
// TESTING
//  1. Reset, then read all 4 registers -> ack after 1 clk; rdata 0 for each; irq=0; idle=1.
//  2. Write buf[0..3]=A0..A3, LENGTH=4, MAX_BURST=2, CTRL=0x03 -> start pulses 1 clk; rw=1;
//     DB reads idx 0..3 -> A0..A3; done pulse -> STATUS=0x02.
//  3. CTRL=0x06, then start with dir=0, DB writes idx 5=0x5A, done -> irq=1; RC read buf[5]=0x5A;
//     write STATUS=0x02 -> irq=0.
//  4. Busy; RC writes LENGTH=9 -> LENGTH unchanged; STATUS.err=1; second CTRL start -> no extra pulse.
//  5. LENGTH=0, CTRL=0x01 -> no start pulse; STATUS.done=1 next cycle.
//  6. Assert rst during BUSY -> outputs 0 immediately; after release, a DB done pulse has no effect.

Source files
------------

// File: rtl/burst_pkg.sv
// rtl/burst_pkg.sv - shared register map, bit positions and FSM states for burst_reg_bank
package burst_pkg;

    localparam logic [1:0] LENGTH_OFF    = 2'd0;
    localparam logic [1:0] MAX_BURST_OFF = 2'd1;
    localparam logic [1:0] CTRL_OFF      = 2'd2;
    localparam logic [1:0] STATUS_OFF    = 2'd3;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_DIR_BIT    = 1;
    localparam int CTRL_IRQ_EN_BIT = 2;

    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;
    localparam int STATUS_ERR_BIT  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } brb_state_t;

endpackage

// File: rtl/brb_buffer.sv
// rtl/brb_buffer.sv - DEPTH x DATA_W single-port buffer RAM with registered read
module brb_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Contents are deliberately not reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/burst_reg_bank.sv
// rtl/burst_reg_bank.sv - register bank and data buffer between the APB register controller
// and the data burst controller, with start/busy/done transfer sequencing and sticky status
module burst_reg_bank #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rc_rb_req,
    input  logic              rc_rb_rw,
    input  logic [ADDR_W-1:0] rc_rb_addr,
    input  logic [DATA_W-1:0] rc_rb_wdata,
    output logic              rb_rc_ack,
    output logic [DATA_W-1:0] rb_rc_rdata,
    input  logic              db_rb_req,
    input  logic              db_rb_we,
    input  logic [ADDR_W-2:0] db_rb_addr,
    input  logic [DATA_W-1:0] db_rb_wdata,
    output logic              rb_db_ack,
    output logic [DATA_W-1:0] rb_db_rdata,
    input  logic              db_rb_done,
    output logic              rb_db_start,
    output logic              rb_db_rw,
    output logic [DATA_W-1:0] rb_db_length,
    output logic [DATA_W-1:0] rb_db_max_burst_size,
    output logic              irq,
    output logic              idle
);

    import burst_pkg::*;

    localparam int IDX_W = ADDR_W - 1;

    brb_state_t        r_state;
    logic              r_start;
    logic              r_idle;
    logic [DATA_W-1:0] r_length;
    logic [DATA_W-1:0] r_max_burst;
    logic              r_dir;
    logic              r_irq_en;
    logic              r_done;
    logic              r_err;
    logic              r_rc_ack;
    logic              r_rc_buf;
    logic [DATA_W-1:0] r_rc_rdata;
    logic              r_db_ack;
    logic              r_db_buf;

    logic              w_busy;
    logic              w_is_buf;
    logic              w_is_reg;
    logic [1:0]        w_off;
    logic              w_rc_wr;
    logic              w_rc_rd;
    logic              w_wr_len;
    logic              w_wr_mb;
    logic              w_wr_ctrl;
    logic              w_wr_status;
    logic              w_start_req;
    logic              w_len_zero;
    logic              w_done_set;
    logic              w_done_clr;
    logic              w_err_set;
    logic              w_err_clr;
    logic [DATA_W-1:0] w_reg_rdata;
    logic              w_buf_en;
    logic              w_buf_we;
    logic [IDX_W-1:0]  w_buf_addr;
    logic [DATA_W-1:0] w_buf_wdata;
    logic [DATA_W-1:0] w_buf_q;

    assign w_busy      = (r_state != IDLE);
    assign w_is_buf    = ~rc_rb_addr[ADDR_W-1];
    assign w_is_reg    = rc_rb_addr[ADDR_W-1] & ({1'b0, rc_rb_addr[ADDR_W-2:0]} < ADDR_W'(4));
    assign w_off       = rc_rb_addr[1:0];
    assign w_rc_wr     = rc_rb_req & rc_rb_rw;
    assign w_rc_rd     = rc_rb_req & ~rc_rb_rw;
    assign w_wr_len    = w_rc_wr & w_is_reg & (w_off == LENGTH_OFF);
    assign w_wr_mb     = w_rc_wr & w_is_reg & (w_off == MAX_BURST_OFF);
    assign w_wr_ctrl   = w_rc_wr & w_is_reg & (w_off == CTRL_OFF);
    assign w_wr_status = w_rc_wr & w_is_reg & (w_off == STATUS_OFF);
    assign w_len_zero  = (r_length == '0);
    assign w_start_req = w_wr_ctrl & rc_rb_wdata[CTRL_START_BIT] & ~w_busy;

    // A CTRL write while busy only counts as an error if it tries to start or flip dir;
    // irq_en stays writable at any time.
    assign w_err_set = w_busy & ((rc_rb_req & w_is_buf) | w_wr_len | w_wr_mb |
                       (w_wr_ctrl & (rc_rb_wdata[CTRL_START_BIT] |
                                     (rc_rb_wdata[CTRL_DIR_BIT] != r_dir))));
    assign w_err_clr  = w_wr_status & rc_rb_wdata[STATUS_ERR_BIT];
    assign w_done_set = (r_state == DONE) | (w_start_req & w_len_zero);
    assign w_done_clr = w_wr_status & rc_rb_wdata[STATUS_DONE_BIT];

    always_comb begin
        w_reg_rdata = '0;
        if (w_is_reg) begin
            case (w_off)
                LENGTH_OFF:    w_reg_rdata = r_length;
                MAX_BURST_OFF: w_reg_rdata = r_max_burst;
                CTRL_OFF: begin
                    w_reg_rdata[CTRL_DIR_BIT]    = r_dir;
                    w_reg_rdata[CTRL_IRQ_EN_BIT] = r_irq_en;
                end
                default: begin
                    w_reg_rdata[STATUS_BUSY_BIT] = w_busy;
                    w_reg_rdata[STATUS_DONE_BIT] = r_done;
                    w_reg_rdata[STATUS_ERR_BIT]  = r_err;
                end
            endcase
        end
    end

    // The single RAM port belongs to DB whenever a transfer is in flight, else to RC.
    assign w_buf_en    = w_busy ? db_rb_req   : (rc_rb_req & w_is_buf);
    assign w_buf_we    = w_busy ? db_rb_we    : rc_rb_rw;
    assign w_buf_addr  = w_busy ? db_rb_addr  : rc_rb_addr[ADDR_W-2:0];
    assign w_buf_wdata = w_busy ? db_rb_wdata : rc_rb_wdata;

    brb_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_buffer (
        .clk     (clk),
        .i_en    (w_buf_en),
        .i_we    (w_buf_we),
        .i_addr  (w_buf_addr),
        .i_wdata (w_buf_wdata),
        .o_rdata (w_buf_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_start <= 1'b0;
            r_idle  <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_idle  <= ~rc_rb_req & ~db_rb_req & ((r_state == IDLE) | (r_state == DONE));
            case (r_state)
                IDLE: begin
                    if (w_start_req && !w_len_zero) begin
                        r_state <= START;
                        r_start <= 1'b1;
                    end
                end
                START: r_state <= BUSY;
                BUSY: begin
                    if (db_rb_done) begin
                        r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_length    <= '0;
            r_max_burst <= '0;
            r_dir       <= 1'b0;
            r_irq_en    <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_wr_len && !w_busy) begin
                r_length <= rc_rb_wdata;
            end
            if (w_wr_mb && !w_busy) begin
                r_max_burst <= rc_rb_wdata;
            end
            if (w_wr_ctrl) begin
                r_irq_en <= rc_rb_wdata[CTRL_IRQ_EN_BIT];
                if (!w_busy) begin
                    r_dir <= rc_rb_wdata[CTRL_DIR_BIT];
                end
            end
            // Sets win over a simultaneous write-1-to-clear.
            r_done <= w_done_set | (r_done & ~w_done_clr);
            r_err  <= w_err_set  | (r_err  & ~w_err_clr);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rc_ack   <= 1'b0;
            r_rc_buf   <= 1'b0;
            r_rc_rdata <= '0;
            r_db_ack   <= 1'b0;
            r_db_buf   <= 1'b0;
        end else begin
            r_rc_ack   <= rc_rb_req;
            r_rc_buf   <= w_rc_rd & w_is_buf & ~w_busy;
            r_rc_rdata <= w_rc_rd ? w_reg_rdata : '0;
            r_db_ack   <= db_rb_req;
            r_db_buf   <= db_rb_req & ~db_rb_we & w_busy;
        end
    end

    assign rb_rc_ack            = r_rc_ack;
    assign rb_rc_rdata          = r_rc_buf ? w_buf_q : r_rc_rdata;
    assign rb_db_ack            = r_db_ack;
    assign rb_db_rdata          = r_db_buf ? w_buf_q : '0;
    assign rb_db_start          = r_start;
    assign rb_db_rw             = r_dir;
    assign rb_db_length         = r_length;
    assign rb_db_max_burst_size = r_max_burst;
    assign irq                  = r_done & r_irq_en;
    assign idle                 = r_idle;

endmodule

// File: tb/tb_burst_reg_bank.sv
// tb/tb_burst_reg_bank.sv - directed self-checking bench for burst_reg_bank
module tb_burst_reg_bank;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 9;

    localparam logic [ADDR_W-1:0] A_LEN    = 9'd256;
    localparam logic [ADDR_W-1:0] A_MB     = 9'd257;
    localparam logic [ADDR_W-1:0] A_CTRL   = 9'd258;
    localparam logic [ADDR_W-1:0] A_STATUS = 9'd259;
    localparam logic [ADDR_W-1:0] A_UNMAP  = 9'd260;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rc_rb_req = 1'b0;
    logic              rc_rb_rw = 1'b0;
    logic [ADDR_W-1:0] rc_rb_addr = '0;
    logic [DATA_W-1:0] rc_rb_wdata = '0;
    logic              rb_rc_ack;
    logic [DATA_W-1:0] rb_rc_rdata;
    logic              db_rb_req = 1'b0;
    logic              db_rb_we = 1'b0;
    logic [ADDR_W-2:0] db_rb_addr = '0;
    logic [DATA_W-1:0] db_rb_wdata = '0;
    logic              rb_db_ack;
    logic [DATA_W-1:0] rb_db_rdata;
    logic              db_rb_done = 1'b0;
    logic              rb_db_start;
    logic              rb_db_rw;
    logic [DATA_W-1:0] rb_db_length;
    logic [DATA_W-1:0] rb_db_max_burst_size;
    logic              irq;
    logic              idle;

    int n_checks = 0;
    int n_errors = 0;
    int n_start  = 0;
    int s;

    burst_reg_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dut (
        .clk                  (clk),
        .rst                  (rst),
        .rc_rb_req            (rc_rb_req),
        .rc_rb_rw             (rc_rb_rw),
        .rc_rb_addr           (rc_rb_addr),
        .rc_rb_wdata          (rc_rb_wdata),
        .rb_rc_ack            (rb_rc_ack),
        .rb_rc_rdata          (rb_rc_rdata),
        .db_rb_req            (db_rb_req),
        .db_rb_we             (db_rb_we),
        .db_rb_addr           (db_rb_addr),
        .db_rb_wdata          (db_rb_wdata),
        .rb_db_ack            (rb_db_ack),
        .rb_db_rdata          (rb_db_rdata),
        .db_rb_done           (db_rb_done),
        .rb_db_start          (rb_db_start),
        .rb_db_rw             (rb_db_rw),
        .rb_db_length         (rb_db_length),
        .rb_db_max_burst_size (rb_db_max_burst_size),
        .irq                  (irq),
        .idle                 (idle)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rb_db_start === 1'b1) n_start++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic rc_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        rc_rb_req = 1'b1; rc_rb_rw = 1'b1; rc_rb_addr = a; rc_rb_wdata = d;
        @(negedge clk);
        rc_rb_req = 1'b0; rc_rb_rw = 1'b0;
    endtask

    task automatic rc_expect(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
        @(negedge clk);
        rc_rb_req = 1'b1; rc_rb_rw = 1'b0; rc_rb_addr = a;
        @(negedge clk);
        rc_rb_req = 1'b0;
        check_eq({tag, "_ack"}, 32'(rb_rc_ack), 32'd1);
        check_eq(tag, 32'(rb_rc_rdata), 32'(exp));
    endtask

    task automatic db_access(input string tag, input logic we, input logic [ADDR_W-2:0] idx,
                             input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] exp);
        @(negedge clk);
        db_rb_req = 1'b1; db_rb_we = we; db_rb_addr = idx; db_rb_wdata = wd;
        @(negedge clk);
        db_rb_req = 1'b0; db_rb_we = 1'b0;
        check_eq({tag, "_ack"}, 32'(rb_db_ack), 32'd1);
        if (!we) check_eq(tag, 32'(rb_db_rdata), 32'(exp));
    endtask

    task automatic db_done_pulse();
        @(negedge clk);
        db_rb_done = 1'b1;
        @(negedge clk);
        db_rb_done = 1'b0;
    endtask

    initial begin
        // 1. reset state and register reads
        repeat (3) @(negedge clk);
        check_eq("rst_idle", 32'(idle), 32'd0);
        check_eq("rst_irq", 32'(irq), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_after_rst", 32'(idle), 32'd1);
        rc_expect("rst_len", A_LEN, 8'h00);
        rc_expect("rst_mb", A_MB, 8'h00);
        rc_expect("rst_ctrl", A_CTRL, 8'h00);
        rc_expect("rst_status", A_STATUS, 8'h00);
        rc_write(A_UNMAP, 8'hFF);
        rc_expect("unmapped", A_UNMAP, 8'h00);

        // 2. dir=1 transfer, DB reads the buffer
        for (int i = 0; i < 4; i++) rc_write(9'(i), 8'(8'hA0 + i));
        rc_write(A_LEN, 8'd4);
        rc_write(A_MB, 8'd2);
        @(negedge clk);
        rc_rb_req = 1'b1; rc_rb_rw = 1'b0; rc_rb_addr = A_LEN;
        @(negedge clk);
        check_eq("b2b_ack1", 32'(rb_rc_ack), 32'd1);
        check_eq("b2b_len", 32'(rb_rc_rdata), 32'd4);
        rc_rb_addr = A_MB;
        @(negedge clk);
        rc_rb_req = 1'b0;
        check_eq("b2b_ack2", 32'(rb_rc_ack), 32'd1);
        check_eq("b2b_mb", 32'(rb_rc_rdata), 32'd2);
        s = n_start;
        rc_write(A_CTRL, 8'h03);
        check_eq("t2_start", 32'(rb_db_start), 32'd1);
        check_eq("t2_rw", 32'(rb_db_rw), 32'd1);
        check_eq("t2_length", 32'(rb_db_length), 32'd4);
        check_eq("t2_maxburst", 32'(rb_db_max_burst_size), 32'd2);
        @(negedge clk);
        check_eq("t2_start_gone", 32'(rb_db_start), 32'd0);
        rc_expect("t2_status_busy", A_STATUS, 8'h01);
        for (int i = 0; i < 4; i++) db_access("t2_db_rd", 1'b0, 8'(i), 8'h00, 8'(8'hA0 + i));
        db_done_pulse();
        rc_expect("t2_status_done", A_STATUS, 8'h02);
        check_eq("t2_pulses", 32'(n_start - s), 32'd1);
        rc_write(A_STATUS, 8'h02);

        // 3. dir=0 transfer with irq, DB writes the buffer
        rc_write(A_CTRL, 8'h06);
        rc_expect("t3_ctrl", A_CTRL, 8'h06);
        check_eq("t3_irq_pre", 32'(irq), 32'd0);
        rc_write(A_CTRL, 8'h05);
        check_eq("t3_rw", 32'(rb_db_rw), 32'd0);
        @(negedge clk);
        db_access("t3_db_wr", 1'b1, 8'd5, 8'h5A, 8'h00);
        db_done_pulse();
        @(negedge clk);
        check_eq("t3_irq", 32'(irq), 32'd1);
        rc_expect("t3_buf5", 9'd5, 8'h5A);
        rc_write(A_STATUS, 8'h02);
        check_eq("t3_irq_clr", 32'(irq), 32'd0);

        // DB access while idle: reads 0, writes ignored
        db_access("idle_db_rd", 1'b0, 8'd0, 8'h00, 8'h00);
        db_access("idle_db_wr", 1'b1, 8'd0, 8'hEE, 8'h00);
        rc_expect("idle_buf0", 9'd0, 8'hA0);

        // 4. writes while busy are dropped and flag err
        s = n_start;
        rc_write(A_CTRL, 8'h01);
        rc_write(A_LEN, 8'd9);
        rc_expect("t4_len", A_LEN, 8'd4);
        rc_expect("t4_buf_busy", 9'd5, 8'h00);
        rc_expect("t4_status", A_STATUS, 8'h05);
        rc_write(A_CTRL, 8'h01);
        repeat (3) @(negedge clk);
        check_eq("t4_pulses", 32'(n_start - s), 32'd1);
        db_done_pulse();
        rc_expect("t4_status_done", A_STATUS, 8'h06);
        rc_write(A_STATUS, 8'h06);
        rc_expect("t4_status_clr", A_STATUS, 8'h00);

        // 5. LENGTH=0 completes immediately without a start pulse
        rc_write(A_LEN, 8'd0);
        s = n_start;
        rc_write(A_CTRL, 8'h01);
        check_eq("t5_no_start", 32'(rb_db_start), 32'd0);
        rc_expect("t5_status", A_STATUS, 8'h02);
        check_eq("t5_pulses", 32'(n_start - s), 32'd0);
        rc_write(A_STATUS, 8'h02);

        // done set by the FSM beats a same-cycle W1C
        rc_write(A_LEN, 8'd1);
        rc_write(A_CTRL, 8'h01);
        @(negedge clk);
        db_rb_done = 1'b1;
        @(negedge clk);
        db_rb_done = 1'b0;
        rc_rb_req = 1'b1; rc_rb_rw = 1'b1; rc_rb_addr = A_STATUS; rc_rb_wdata = 8'h02;
        @(negedge clk);
        rc_rb_req = 1'b0; rc_rb_rw = 1'b0;
        rc_expect("set_wins", A_STATUS, 8'h02);
        rc_write(A_STATUS, 8'h02);

        // 6. asynchronous reset during BUSY
        rc_write(A_LEN, 8'd3);
        s = n_start;
        rc_write(A_CTRL, 8'h01);
        @(negedge clk);
        check_eq("t6_len_busy", 32'(rb_db_length), 32'd3);
        #2 rst = 1'b1;
        #1;
        check_eq("t6_len_rst", 32'(rb_db_length), 32'd0);
        check_eq("t6_idle_rst", 32'(idle), 32'd0);
        check_eq("t6_start_rst", 32'(rb_db_start), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        db_done_pulse();
        repeat (3) @(negedge clk);
        check_eq("t6_pulses", 32'(n_start - s), 32'd1);
        rc_expect("t6_status", A_STATUS, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
